simple_gan_layer_seq: RTL and testbench
=======================================

Name: simple_gan_layer_seq

Overview:
Sequencer for one dense layer of the Simple GAN (Gen 2->3, 3->9; Disc 9->3, 3->1).
- Walks the row-major weight and bias addresses of a synchronous 1-cycle-latency weight ROM.
- Issues latency-aligned MAC strobes (accumulate, first-term load, bias add) and marks each finished neuron.
- One instance is shared across layers; the layer shape is configured at run time on start.

Parameters:
MAX_DIM, 9, largest legal n_in / n_out
DIM_W, 4, width of dimension and index fields
WADDR_W, 7, weight address width (covers MAX_DIM*MAX_DIM-1 = 80)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  request one layer pass; sampled only in IDLE
abort  in  1  synchronous cancel; returns to IDLE
cfg_n_in  in  DIM_W  inputs per neuron; latched on accepted start
cfg_n_out  in  DIM_W  neurons in layer; latched on accepted start
busy  out  1  pass in progress
done  out  1  1-cycle pulse, same cycle as the last neuron_valid
cfg_err  out  1  1-cycle pulse when start carries an illegal cfg
w_addr  out  WADDR_W  weight ROM address, = j*n_in+i
b_addr  out  DIM_W  bias ROM address, = j
x_idx  out  DIM_W  input-vector index i, aligned with ROM weight data
mac_en  out  1  ROM weight data valid this cycle; MAC multiplies x[x_idx]*w
mac_first  out  1  with mac_en: load the product instead of accumulating
bias_en  out  1  ROM bias data valid this cycle; MAC adds the bias
neuron_valid  out  1  accumulator holds the finished neuron neuron_idx
neuron_idx  out  DIM_W  neuron index j for neuron_valid

Behaviour:
- Reset: every output is 0, state IDLE, counters 0. All outputs are registered.
- Cycle k is the period after clock edge k. A start accepted at edge 0 puts state RUN in cycle 1, with busy=1 and w_addr=0.
- Legal cfg: 1 <= n_in, n_out <= MAX_DIM. A start with an illegal cfg gives cfg_err=1 for one cycle, stays IDLE, and busy stays 0.
- States:
  - IDLE.
  - RUN: issues w_addr for i=0..n_in-1, one per cycle, incrementing w_addr by 1.
  - BIAS: 1 cycle, issues b_addr=j. Then j++; if j<n_out go to RUN, else go to DRAIN.
  - DRAIN: 2 cycles.
  - Then back to IDLE.
- Latency alignment:
  - mac_en/x_idx are the address-issue strobe and i delayed 1 cycle.
  - mac_first is set on the i=0 term.
  - bias_en is the BIAS-state strobe delayed 1 cycle.
  - neuron_valid/neuron_idx are bias_en/j delayed 1 cycle.
- Throughput: each neuron costs n_in+1 cycles. neuron_valid(j) may coincide with mac_first of neuron j+1; this is legal because the MAC reads the accumulator before the edge.
- busy lasts exactly n_out*(n_in+1)+2 cycles. done pulses in the final busy cycle; busy=0 the next cycle.
- w_addr never exceeds n_in*n_out-1. It holds its last value in DRAIN/IDLE and is 0 after reset.
- start while busy: ignored, no error.
- A start in the same cycle as done's IDLE return is accepted on the following edge only.
- abort, or rst, mid-pass: next cycle is IDLE with all strobes 0. No done and no further neuron_valid. In-flight delayed strobes are squashed. abort has priority over start.
- Config is held constant through a pass even if the cfg inputs change.

Test Plan:
1. Gen L1, n_in=2, n_out=3; start at edge 0 -> w_addr 0,1 (c1-2), 2,3 (c4-5), 4,5 (c7-8). mac_first in c2,c5,c8. bias_en in c4,c7,c10. neuron_valid j=0,1,2 in c5,c8,c11. done in c11; busy in c1..c11.
2. Disc L2, n_in=3, n_out=1 -> w_addr 0,1,2; b_addr=0 in c4; bias_en in c5; neuron_valid+done in c6; busy 6 cycles.
3. Gen L2, n_in=3, n_out=9 -> w_addr 0..26 strictly incrementing; 9 neuron_valid with idx 0..8; done in c38; x_idx repeats 0,1,2 aligned with mac_en.
4. n_in=1, n_out=2 -> every mac_en also has mac_first; bias_en in c3,c5; neuron_valid in c4,c6; done in c6.
5. cfg_n_in=0 or cfg_n_out=10 with start -> cfg_err for 1 cycle; busy, mac_en and done stay 0.
6. Abort at c4 of test 1 -> c5 onward all outputs 0 except w_addr hold, no done. A start pulsed at c2 of test 1 has no effect. rst at c3 gives the same result as abort.

Source files
------------

// File: rtl/simple_gan_layer_seq.sv
// Address/strobe sequencer for one dense layer of the Simple GAN MAC datapath.
// Drives a 1-cycle-latency weight/bias ROM and emits latency-aligned MAC control.
module simple_gan_layer_seq #(
  parameter int MAX_DIM = 9,
  parameter int DIM_W   = 4,
  parameter int WADDR_W = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [DIM_W-1:0]   cfg_n_in,
  input  logic [DIM_W-1:0]   cfg_n_out,
  output logic               busy,
  output logic               done,
  output logic               cfg_err,
  output logic [WADDR_W-1:0] w_addr,
  output logic [DIM_W-1:0]   b_addr,
  output logic [DIM_W-1:0]   x_idx,
  output logic               mac_en,
  output logic               mac_first,
  output logic               bias_en,
  output logic               neuron_valid,
  output logic [DIM_W-1:0]   neuron_idx
);

  typedef enum logic [1:0] {IDLE, RUN, BIAS, DRAIN} state_t;

  localparam logic [DIM_W-1:0] MAX_V = DIM_W'(MAX_DIM);
  localparam logic [DIM_W-1:0] ONE   = DIM_W'(1);

  state_t           state;
  logic [DIM_W-1:0] n_in, n_out;
  logic [DIM_W-1:0] i_cnt, j_cnt;
  logic [DIM_W-1:0] bias_j;
  logic             drain_cnt;
  logic             cfg_ok;

  assign cfg_ok = (cfg_n_in  != '0) && (cfg_n_in  <= MAX_V) &&
                  (cfg_n_out != '0) && (cfg_n_out <= MAX_V);

  // NOTE: every register here uses <= so all updates see pre-edge values;
  // the delayed strobes rely on that to form a clean 1-cycle pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      n_in         <= '0;
      n_out        <= '0;
      i_cnt        <= '0;
      j_cnt        <= '0;
      bias_j       <= '0;
      drain_cnt    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      cfg_err      <= 1'b0;
      w_addr       <= '0;
      b_addr       <= '0;
      x_idx        <= '0;
      mac_en       <= 1'b0;
      mac_first    <= 1'b0;
      bias_en      <= 1'b0;
      neuron_valid <= 1'b0;
      neuron_idx   <= '0;
    end else begin
      // ROM-latency delay stage: what was issued last cycle becomes valid now
      done         <= 1'b0;
      cfg_err      <= 1'b0;
      mac_en       <= (state == RUN);
      mac_first    <= (state == RUN) && (i_cnt == '0);
      x_idx        <= (state == RUN) ? i_cnt : '0;
      bias_en      <= (state == BIAS);
      bias_j       <= j_cnt;
      neuron_valid <= bias_en;
      neuron_idx   <= bias_en ? bias_j : '0;

      if (abort) begin
        // Squash everything in flight; w_addr deliberately keeps its value
        state        <= IDLE;
        busy         <= 1'b0;
        i_cnt        <= '0;
        j_cnt        <= '0;
        drain_cnt    <= 1'b0;
        b_addr       <= '0;
        x_idx        <= '0;
        mac_en       <= 1'b0;
        mac_first    <= 1'b0;
        bias_en      <= 1'b0;
        neuron_valid <= 1'b0;
        neuron_idx   <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              if (cfg_ok) begin
                state  <= RUN;
                busy   <= 1'b1;
                n_in   <= cfg_n_in;
                n_out  <= cfg_n_out;
                i_cnt  <= '0;
                j_cnt  <= '0;
                w_addr <= '0;
              end else begin
                cfg_err <= 1'b1;
              end
            end
          end
          RUN: begin
            if (i_cnt == n_in - ONE) begin
              state  <= BIAS;
              i_cnt  <= '0;
              b_addr <= j_cnt;
            end else begin
              i_cnt  <= i_cnt + ONE;
              w_addr <= w_addr + WADDR_W'(1);
            end
          end
          BIAS: begin
            if (j_cnt + ONE < n_out) begin
              state  <= RUN;
              j_cnt  <= j_cnt + ONE;
              w_addr <= w_addr + WADDR_W'(1);
            end else begin
              state     <= DRAIN;
              j_cnt     <= '0;
              drain_cnt <= 1'b0;
            end
          end
          DRAIN: begin
            // Two cycles let the last bias and neuron_valid leave the pipeline
            if (!drain_cnt) begin
              drain_cnt <= 1'b1;
              done      <= 1'b1;
            end else begin
              state     <= IDLE;
              busy      <= 1'b0;
              drain_cnt <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_simple_gan_layer_seq.sv
// Directed bench for simple_gan_layer_seq: hand-computed cycle tables for the
// GAN layer shapes, illegal configs, abort and mid-pass reset.
module tb_simple_gan_layer_seq;

  logic       clk = 1'b0;
  logic       rst, start, abort;
  logic [3:0] cfg_n_in, cfg_n_out;
  logic       busy, done, cfg_err, mac_en, mac_first, bias_en, neuron_valid;
  logic [6:0] w_addr;
  logic [3:0] b_addr, x_idx, neuron_idx;
  logic [5:0] strobes;

  int errors = 0;
  int checks = 0;

  simple_gan_layer_seq #(.MAX_DIM(9), .DIM_W(4), .WADDR_W(7)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_n_in(cfg_n_in), .cfg_n_out(cfg_n_out),
    .busy(busy), .done(done), .cfg_err(cfg_err),
    .w_addr(w_addr), .b_addr(b_addr), .x_idx(x_idx),
    .mac_en(mac_en), .mac_first(mac_first), .bias_en(bias_en),
    .neuron_valid(neuron_valid), .neuron_idx(neuron_idx)
  );

  always #5 clk = ~clk;

  // {busy, done, mac_en, mac_first, bias_en, neuron_valid}
  assign strobes = {busy, done, mac_en, mac_first, bias_en, neuron_valid};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag, input logic [6:0] wexp);
    check({tag, " strobes"}, 32'(strobes), 32'd0);
    check({tag, " cfg_err"}, 32'(cfg_err), 32'd0);
    check({tag, " x_idx"}, 32'(x_idx), 32'd0);
    check({tag, " b_addr"}, 32'(b_addr), 32'd0);
    check({tag, " neuron_idx"}, 32'(neuron_idx), 32'd0);
    check({tag, " w_addr"}, 32'(w_addr), 32'(wexp));
  endtask

  // Gen L1 (2->3): cycles 1..12
  logic [5:0] t1_s [12] = '{6'b100000, 6'b101100, 6'b101000, 6'b100010,
                            6'b101101, 6'b101000, 6'b100010, 6'b101101,
                            6'b101000, 6'b100010, 6'b110001, 6'b000000};
  int         t1_w [12] = '{0, 1, 1, 2, 3, 3, 4, 5, 5, 5, 5, 5};
  int         t1_x [12] = '{0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0};
  // Disc L2 (3->1): cycles 1..7
  logic [5:0] t2_s [7]  = '{6'b100000, 6'b101100, 6'b101000, 6'b101000,
                            6'b100010, 6'b110001, 6'b000000};
  int         t2_w [7]  = '{0, 1, 2, 2, 2, 2, 2};
  // n_in=1, n_out=2: cycles 1..7
  logic [5:0] t4_s [7]  = '{6'b100000, 6'b101100, 6'b100010, 6'b101101,
                            6'b100010, 6'b110001, 6'b000000};
  int         t4_w [7]  = '{0, 0, 1, 1, 1, 1, 1};

  task automatic launch(input logic [3:0] ni, input logic [3:0] no);
    cfg_n_in  = ni;
    cfg_n_out = no;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  initial begin
    int m, nv;
    logic [6:0] prev_w;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    cfg_n_in = '0; cfg_n_out = '0;
    tick();
    tick();
    check_quiet("reset", 7'd0);
    rst = 1'b0;
    tick();

    // Gen L1; a mid-pass start and cfg change must not disturb the pass
    launch(4'd2, 4'd3);
    for (int c = 1; c <= 12; c++) begin
      if (c > 1) tick();
      check($sformatf("t1 c%0d strobes", c), 32'(strobes), 32'(t1_s[c-1]));
      check($sformatf("t1 c%0d w_addr", c), 32'(w_addr), 32'(t1_w[c-1]));
      if (mac_en) check($sformatf("t1 c%0d x_idx", c), 32'(x_idx), 32'(t1_x[c-1]));
      if (c == 3 || c == 6 || c == 9)
        check($sformatf("t1 c%0d b_addr", c), 32'(b_addr), 32'(c / 3 - 1));
      if (c == 5 || c == 8 || c == 11)
        check($sformatf("t1 c%0d neuron_idx", c), 32'(neuron_idx), 32'((c - 5) / 3));
      check($sformatf("t1 c%0d cfg_err", c), 32'(cfg_err), 32'd0);
      if (c == 2) begin
        start = 1'b1; cfg_n_in = 4'd5; cfg_n_out = 4'd1;
      end else begin
        start = 1'b0;
      end
    end

    // Disc L2; start held across done is accepted only after IDLE return
    launch(4'd3, 4'd1);
    for (int c = 1; c <= 7; c++) begin
      if (c > 1) tick();
      check($sformatf("t2 c%0d strobes", c), 32'(strobes), 32'(t2_s[c-1]));
      check($sformatf("t2 c%0d w_addr", c), 32'(w_addr), 32'(t2_w[c-1]));
      if (c == 4) check("t2 c4 b_addr", 32'(b_addr), 32'd0);
      if (c == 6) start = 1'b1;
    end
    tick();
    start = 1'b0;
    check("t2 restart busy", 32'(busy), 32'd1);
    check("t2 restart w_addr", 32'(w_addr), 32'd0);
    for (int c = 0; c < 6; c++) tick();
    check("t2 restart ended", 32'(busy), 32'd0);

    // Gen L2 (3->9)
    m = 0; nv = 0; prev_w = '0;
    launch(4'd3, 4'd9);
    for (int c = 1; c <= 39; c++) begin
      if (c > 1) tick();
      if (mac_en) begin
        check($sformatf("t3 c%0d x_idx", c), 32'(x_idx), 32'(m % 3));
        check($sformatf("t3 c%0d w_addr seq", c), 32'(prev_w), 32'(m));
        check($sformatf("t3 c%0d mac_first", c), 32'(mac_first), 32'(m % 3 == 0));
        m++;
      end
      if (neuron_valid) begin
        check($sformatf("t3 c%0d neuron_idx", c), 32'(neuron_idx), 32'(nv));
        nv++;
      end
      check($sformatf("t3 c%0d busy", c), 32'(busy), 32'(c <= 38));
      check($sformatf("t3 c%0d done", c), 32'(done), 32'(c == 38));
      prev_w = w_addr;
    end
    check("t3 mac count", 32'(m), 32'd27);
    check("t3 neuron count", 32'(nv), 32'd9);
    check("t3 final w_addr", 32'(w_addr), 32'd26);

    // n_in=1: every term is a first term
    launch(4'd1, 4'd2);
    for (int c = 1; c <= 7; c++) begin
      if (c > 1) tick();
      check($sformatf("t4 c%0d strobes", c), 32'(strobes), 32'(t4_s[c-1]));
      check($sformatf("t4 c%0d w_addr", c), 32'(w_addr), 32'(t4_w[c-1]));
    end

    // Illegal configs
    launch(4'd0, 4'd3);
    check("t5 n_in=0 cfg_err", 32'(cfg_err), 32'd1);
    check("t5 n_in=0 strobes", 32'(strobes), 32'd0);
    tick();
    check("t5 n_in=0 err pulse", 32'(cfg_err), 32'd0);
    check("t5 n_in=0 idle", 32'(strobes), 32'd0);
    launch(4'd3, 4'd10);
    check("t5 n_out=10 cfg_err", 32'(cfg_err), 32'd1);
    check("t5 n_out=10 strobes", 32'(strobes), 32'd0);
    tick();
    check("t5 n_out=10 err pulse", 32'(cfg_err), 32'd0);

    // Abort at c4 of Gen L1
    launch(4'd2, 4'd3);
    for (int c = 1; c <= 4; c++) begin
      if (c > 1) tick();
      check($sformatf("t6 c%0d strobes", c), 32'(strobes), 32'(t1_s[c-1]));
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    for (int c = 5; c <= 13; c++) begin
      if (c > 5) tick();
      check_quiet($sformatf("t6 abort c%0d", c), 7'd2);
    end

    // abort beats start in IDLE
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("t6 abort over start", 32'(strobes), 32'd0);
    check("t6 abort over start err", 32'(cfg_err), 32'd0);

    // Reset at c3 of Gen L1
    launch(4'd2, 4'd3);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 4; c <= 12; c++) begin
      if (c > 4) tick();
      check_quiet($sformatf("t6 rst c%0d", c), 7'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
